// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock through a registered carry.
// Define ADDSUB_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags are tied low.
module addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic [CHUNK:0]   chunk_add;
    logic [31:0]      base;
    logic             load_out;

    always_comb begin
        base      = 32'(k_q) * CHUNK;
        chunk_add = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        k_d      = k_q;
        sum_d    = sum_q;
        s_d      = s_q;
        co_d     = co_q;
        load_out = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtract mode stores ~b; the caller supplies ci=1 for two's complement.
                    b_d     = m ? ~b : b;
                    carry_d = ci;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[base +: CHUNK] = chunk_add[CHUNK-1:0];
                carry_d              = chunk_add[CHUNK];
                k_d                  = k_q + 1'b1;
                if (k_q == KLast) begin
                    s_d      = sum_d;
                    co_d     = chunk_add[CHUNK];
                    load_out = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic ovf_q, zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (load_out) begin
            // a^b^s at the MSB recovers the carry into the MSB.
            ovf_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ chunk_add[CHUNK];
            zero_q <= (sum_d == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign co        = co_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: an 8/4 and a 16/1 instance checked every cycle against an arithmetic model.
module tb_addsub_seq;

`ifdef ADDSUB_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic iv8, ci8, m8, or8, ir8, ov8, co8, ovf8, z8;
    logic [7:0] a8, b8, s8;
    logic iv16, ci16, m16, or16, ir16, ov16, co16, ovf16, z16;
    logic [15:0] a16, b16, s16;

    addsub_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .ci(ci8), .m(m8), .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8),
        .ovf(ovf8), .zero(z8)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .ci(ci16), .m(m16), .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16),
        .ovf(ovf16), .zero(z16)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic, overflow from the true signed sum.
    function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic m, output logic [15:0] s,
                                  output logic co, output logic ovf, output logic zero);
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint av   = longint'(a);
        longint bv   = m ? ((~longint'(b)) & mask) : longint'(b);
        longint full = av + bv + longint'(ci);
        longint sa   = (av >= half) ? av - 2 * half : av;
        longint sb   = (bv >= half) ? bv - 2 * half : bv;
        longint ts   = sa + sb + longint'(ci);
        s    = 16'(full & mask);
        co   = ((full >> w) & 1) != 0;
        ovf  = (ts >= half) || (ts < -half);
        zero = (full & mask) == 0;
    endfunction

    // Per-instance model state: index 0 = 8/4, index 1 = 16/1.
    int          lat   [2] = '{2, 16};
    logic        busy  [2] = '{1'b0, 1'b0};
    longint      acc   [2];
    logic [15:0] es    [2];
    logic        eco   [2];
    logic        eovf  [2];
    logic        ez    [2];
    int          ndone [2] = '{0, 0};
    longint      cyc = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic        iv, orr, cc, mm;
            logic [15:0] aa, bb;
            if (i == 0) begin
                iv = iv8; orr = or8; aa = {8'h00, a8}; bb = {8'h00, b8}; cc = ci8; mm = m8;
            end else begin
                iv = iv16; orr = or16; aa = a16; bb = b16; cc = ci16; mm = m16;
            end
            if (!rst_n) begin
                busy[i] = 1'b0;
            end else if (!busy[i]) begin
                if (iv) begin
                    model((i == 0) ? 8 : 16, aa, bb, cc, mm, es[i], eco[i], eovf[i], ez[i]);
                    busy[i] = 1'b1;
                    acc[i]  = cyc + 1;
                end
            end else if ((cyc - acc[i] >= longint'(lat[i])) && orr) begin
                busy[i] = 1'b0;
                ndone[i]++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic        ir, ov, c, f, z, eov;
                logic [15:0] sv;
                if (i == 0) begin
                    ir = ir8; ov = ov8; sv = {8'h00, s8}; c = co8; f = ovf8; z = z8;
                end else begin
                    ir = ir16; ov = ov16; sv = s16; c = co16; f = ovf16; z = z16;
                end
                eov = busy[i] && (cyc - acc[i] >= longint'(lat[i]));
                chk($sformatf("dut%0d in_ready", i), 32'(ir), 32'(!busy[i]));
                chk($sformatf("dut%0d out_valid", i), 32'(ov), 32'(eov));
                if (eov && ov) begin
                    chk($sformatf("dut%0d s", i), 32'(sv), 32'(es[i]));
                    chk($sformatf("dut%0d co", i), 32'(c), 32'(eco[i]));
                    chk($sformatf("dut%0d ovf", i), 32'(f), 32'(eovf[i] & FlagsEn));
                    chk($sformatf("dut%0d zero", i), 32'(z), 32'(ez[i] & FlagsEn));
                end
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic m);
        iv8 = 1'b1; a8 = a; b8 = b; ci8 = ci; m8 = m;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                           input logic m);
        iv16 = 1'b1; a16 = a; b16 = b; ci16 = ci; m16 = m;
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!ov8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov8) chk("dut0 out_valid timeout", 32'(ov8), 32'd1);
    endtask

    task automatic wait16(output int n);
        n = 0;
        while (!ov16 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ov16) chk("dut1 out_valid timeout", 32'(ov16), 32'd1);
    endtask

    task automatic drain8();
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
    endtask

    initial begin
        logic [15:0] ms;
        logic        mc, mo, mz;
        int          n;

        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; m8 = 0; or8 = 0;
        iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; m16 = 0; or16 = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        started = 1'b1;

        chk("reset in_ready", 32'(ir8), 32'd1);
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset s", 32'(s8), 32'd0);
        chk("reset co", 32'(co8), 32'd0);
        chk("reset ovf", 32'(ovf8), 32'd0);
        chk("reset zero", 32'(z8), 32'd0);
        chk("reset s16", 32'(s16), 32'd0);

        // Hand-computed values pin the model.
        model(8, 16'h00, 16'hF8, 1'b1, 1'b1, ms, mc, mo, mz);
        chk("model 00-F8 s", 32'(ms), 32'h08);
        chk("model 00-F8 co", 32'(mc), 32'd0);
        model(8, 16'h02, 16'h05, 1'b1, 1'b1, ms, mc, mo, mz);
        chk("model 02-05 s", 32'(ms), 32'hFD);
        model(8, 16'h7F, 16'h01, 1'b0, 1'b0, ms, mc, mo, mz);
        chk("model 7F+01 ovf", 32'(mo), 32'd1);
        model(8, 16'hFF, 16'h01, 1'b0, 1'b0, ms, mc, mo, mz);
        chk("model FF+01 co/zero", 32'({mc, mz, mo}), 32'b110);

        issue8(8'h00, 8'hF8, 1'b1, 1'b1);
        wait8(n);
        chk("lat8", 32'(n), 32'd2);
        chk("00-F8 s", 32'(s8), 32'h08);
        chk("00-F8 co", 32'(co8), 32'd0);
        chk("00-F8 ovf", 32'(ovf8), 32'd0);
        chk("00-F8 zero", 32'(z8), 32'd0);
        drain8();

        issue8(8'h02, 8'h05, 1'b1, 1'b1);
        wait8(n);
        chk("02-05 s", 32'(s8), 32'hFD);
        chk("02-05 co", 32'(co8), 32'd0);
        drain8();

        issue8(8'h7F, 8'h01, 1'b0, 1'b0);
        wait8(n);
        chk("7F+01 s", 32'(s8), 32'h80);
        chk("7F+01 ovf", 32'(ovf8), 32'(FlagsEn));
        drain8();

        issue8(8'hFF, 8'h01, 1'b0, 1'b0);
        wait8(n);
        chk("FF+01 s", 32'(s8), 32'h00);
        chk("FF+01 co", 32'(co8), 32'd1);
        chk("FF+01 zero", 32'(z8), 32'(FlagsEn));
        chk("FF+01 ovf", 32'(ovf8), 32'd0);
        drain8();

        // Backpressure: DONE holds while inputs churn.
        issue8(8'h12, 8'h34, 1'b0, 1'b0);
        wait8(n);
        repeat (5) begin
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            ci8 = 1'($urandom); m8 = 1'($urandom);
            @(posedge clk); #1;
            chk("bp out_valid", 32'(ov8), 32'd1);
            chk("bp in_ready", 32'(ir8), 32'd0);
            chk("bp s", 32'(s8), 32'h46);
        end
        iv8 = 1'b0;
        drain8();
        chk("post-drain in_ready", 32'(ir8), 32'd1);

        // Reset mid-RUN discards the operation.
        issue8(8'h55, 8'h0F, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst in_ready", 32'(ir8), 32'd1);
        chk("rst out_valid", 32'(ov8), 32'd0);
        chk("rst s", 32'(s8), 32'd0);
        chk("rst co", 32'(co8), 32'd0);
        issue8(8'hA0, 8'h50, 1'b0, 1'b0);
        wait8(n);
        chk("A0+50 s", 32'(s8), 32'hF0);
        drain8();

        issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait16(n);
        chk("lat16", 32'(n), 32'd16);
        chk("FFFF+1 s", 32'(s16), 32'h0000);
        chk("FFFF+1 co", 32'(co16), 32'd1);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;

        repeat (3000) begin
            iv8  = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            ci8  = 1'($urandom); m8 = 1'($urandom); or8 = ($urandom_range(0, 3) != 0);
            iv16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
            ci16 = 1'($urandom); m16 = 1'($urandom); or16 = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        iv8 = 1'b0; iv16 = 1'b0; or8 = 1'b1; or16 = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("ops8 completed", 32'(ndone[0] >= 100), 32'd1);
        chk("ops16 completed", 32'(ndone[1] >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, using a registered carry chain and a valid/ready handshake on both sides. It succeeds the combinational 8-bit add/sub unit in the arithmetic datapath. Callers trade latency for a short critical path, and the block adds carry, overflow and zero reporting. One operation is in flight at a time.

## Interface
- WIDTH, 8, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits added per RUN cycle; N = WIDTH/CHUNK cycles per operation
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- ci  in  1  carry-in, used as given; no implicit +1 on subtract
- m  in  1  mode: 0 = a+b+ci, 1 = a+~b+ci
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- s  out  WIDTH  result
- co  out  1  carry-out of the MSB
- ovf  out  1  signed overflow, present only with the flags macro
- zero  out  1  s == 0, present only with the flags macro

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, (m ? ~b : b) and ci; clear chunk counter k to 0; go to RUN.
  - m is sampled only at acceptance.
- RUN:
  - Each cycle, add chunk k of the latched A and B with the carry flop (initialised to ci).
  - Write the CHUNK-bit sum into chunk k of the working register, update the carry flop, and set k++.
  - When k==N-1, take the final carry as co; on the final chunk, record the carry into bit WIDTH-1; go to DONE.
- DONE:
  - out_valid=1.
  - s, co and the flags are copied into output registers on DONE entry.
  - On out_ready, go to IDLE.
- in_ready=0 in RUN and DONE; in_valid is ignored there.
- s, co and flags hold their last value until the next DONE entry. They are meaningful only while out_valid=1.
- Arithmetic:
  - Result modulo 2^WIDTH.
  - co = bit WIDTH of the full sum.
  - ovf = carry-into-MSB XOR co.
  - zero = (s == 0).
- CHUNK==WIDTH is legal (N=1). CHUNK==1 gives a bit-serial adder.
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; an in-flight operation is discarded.
  - Outputs: in_ready=1, out_valid=0, s=0, co=0, ovf=0, zero=0.
  - Reset in any state, including mid-RUN or DONE with out_ready low, behaves the same.

## Timing
- Acceptance edge T0; RUN occupies edges T1..TN; out_valid=1 in the cycle following TN.
- Latency is N cycles from acceptance to out_valid.
- Minimum initiation interval is N+2 cycles: a DONE cycle plus an IDLE cycle.
- out_valid, once high, stays high with s, co and flags stable until the out_ready edge.
- in_ready rises in the cycle after the out_ready handshake edge.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- ADDSUB_FLAGS_EN defined:
  - ovf and zero computed as above and registered on DONE entry.
- ADDSUB_FLAGS_EN undefined:
  - ovf and zero tied to 0 and no flag logic is built.
  - co, s and the handshake are unchanged.

## Test plan
- WIDTH=8, CHUNK=4: a=0x00, b=0xF8, ci=1, m=1 -> out_valid 2 cycles after acceptance; s=0x08, co=0, ovf=0, zero=0.
- a=0x02, b=0x05, ci=1, m=1 -> s=0xFD, co=0, ovf=0; then a=0x7F, b=0x01, ci=0, m=0 -> s=0x80, co=0, ovf=1.
- a=0xFF, b=0x01, ci=0, m=0 -> s=0x00, co=1, zero=1, ovf=0; with ADDSUB_FLAGS_EN undefined, ovf=zero=0 and s and co are identical.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operands -> out_valid=1, s and co stable, in_ready=0, no new operation accepted.
- Reset: drive rst_n=0 for one edge mid-RUN -> next cycle in_ready=1, out_valid=0, s=0; a fresh operation then completes correctly.
- WIDTH=16, CHUNK=1: a=0xFFFF, b=0x0001, ci=0, m=0 -> s=0x0000, co=1, out_valid exactly 16 cycles after acceptance.
